// File: rtl/dahb_ram_block_if.sv
// Dual AHB3-Lite bus bundle for dahb_ram_block: index 0 is the instruction port,
// index 1 the data port.
interface dahb_ram_block_if #(
   parameter int AW = 20
);
   logic [AW-1:0] s_haddr_i     [2];
   logic [31:0]   s_hwdata_i    [2];
   logic [2:0]    s_hburst_i    [2];
   logic          s_hmastlock_i [2];
   logic [3:0]    s_hprot_i     [2];
   logic [2:0]    s_hsize_i     [2];
   logic [1:0]    s_htrans_i    [2];
   logic          s_hwrite_i    [2];
   logic          s_hsel_i      [2];
   logic [31:0]   s_hrdata_o    [2];
   logic          s_hready_o    [2];
   logic          s_hresp_o     [2];

   modport master (
      output s_haddr_i, s_hwdata_i, s_hburst_i, s_hmastlock_i, s_hprot_i,
             s_hsize_i, s_htrans_i, s_hwrite_i, s_hsel_i,
      input  s_hrdata_o, s_hready_o, s_hresp_o
   );

   modport slave (
      input  s_haddr_i, s_hwdata_i, s_hburst_i, s_hmastlock_i, s_hprot_i,
             s_hsize_i, s_htrans_i, s_hwrite_i, s_hsel_i,
      output s_hrdata_o, s_hready_o, s_hresp_o
   );
endinterface

// File: rtl/dahb_ram_block.sv
// Dual-port zero-wait-state AHB3-Lite RAM: two independent slaves sharing one
// little-endian word array, one cycle from address phase to data.
module dahb_ram_block #(
   parameter int unsigned MEM_SIZE   = 32'h100000,
   parameter bit          SIMULATION = 1'b0,
   parameter bit          ENABLE_LOG = 1'b0,
   parameter string       LABEL      = "MEMORY"
) (
   input  logic              s_clk_i,
   input  logic              s_resetn_i,
   dahb_ram_block_if.slave   bus
);
   localparam int AW    = $clog2(MEM_SIZE);
   localparam int WORDS = MEM_SIZE / 4;

   logic [31:0] r_memory [WORDS];

   logic [1:0]         vld_p1;
   logic [1:0]         wr_p1;
   logic [1:0][2:0]    size_p1;
   logic [1:0][AW-1:0] addr_p1;
   logic [1:0][3:0]    be_p1;
   logic               unused_ahb;

   // Sizes above a word select no lanes, so such writes leave memory alone.
   function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] a);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         3'd0:    be = 4'b0001 << a;
         3'd1:    be = a[1] ? 4'b1100 : 4'b0011;
         3'd2:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   assign unused_ahb = ^{bus.s_hburst_i[0], bus.s_hburst_i[1],
                         bus.s_hmastlock_i[0], bus.s_hmastlock_i[1],
                         bus.s_hprot_i[0], bus.s_hprot_i[1]};

   // Address phase -> data phase registers
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         vld_p1  <= '0;
         wr_p1   <= '0;
         size_p1 <= '0;
         addr_p1 <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            vld_p1[p] <= bus.s_hsel_i[p] && bus.s_htrans_i[p][1];
            if (bus.s_hsel_i[p] && bus.s_htrans_i[p][1]) begin
               wr_p1[p]   <= bus.s_hwrite_i[p];
               size_p1[p] <= bus.s_hsize_i[p];
               addr_p1[p] <= bus.s_haddr_i[p];
            end
         end
      end
   end

   always_comb begin
      be_p1 = '0;
      for (int p = 0; p < 2; p++)
         be_p1[p] = byte_lanes(size_p1[p], addr_p1[p][1:0]);
   end

   // Data phase: port 1 is applied last so it wins on a shared byte.
   always_ff @(posedge s_clk_i) begin
      for (int p = 0; p < 2; p++) begin
         if (vld_p1[p] && wr_p1[p]) begin
            for (int b = 0; b < 4; b++) begin
               if (be_p1[p][b])
                  r_memory[addr_p1[p][AW-1:2]][8*b +: 8] <= bus.s_hwdata_i[p][8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         bus.s_hrdata_o[p] = (vld_p1[p] && !wr_p1[p]) ? r_memory[addr_p1[p][AW-1:2]] : 32'h0;
         bus.s_hready_o[p] = 1'b1;
         bus.s_hresp_o[p]  = 1'b0;
      end
   end

   if (SIMULATION && ENABLE_LOG) begin : g_log
      always @(posedge s_clk_i) begin
         for (int p = 0; p < 2; p++) begin
            if (vld_p1[p])
               $display("%s[%0d] %s addr=%h data=%h", LABEL, p, wr_p1[p] ? "W" : "R",
                        addr_p1[p], wr_p1[p] ? bus.s_hwdata_i[p] : bus.s_hrdata_o[p]);
         end
      end
   end

endmodule

// File: tb/tb_dahb_ram_block.sv
// Directed bench for dahb_ram_block: read expectations go through a scoreboard
// queue checked by a negedge monitor; memory contents are checked directly.
module tb_dahb_ram_block;
   localparam int MEM_SIZE = 1024;
   localparam int AW       = 10;

   logic r_ver_clk = 1'b0;
   logic rst_n;
   always #5 r_ver_clk = ~r_ver_clk;

   dahb_ram_block_if #(.AW(AW)) ahb ();

   dahb_ram_block #(
      .MEM_SIZE(MEM_SIZE), .SIMULATION(1'b0), .ENABLE_LOG(1'b0), .LABEL("TBMEM")
   ) dut (
      .s_clk_i(r_ver_clk), .s_resetn_i(rst_n), .bus(ahb)
   );

   typedef struct {
      int          cyc;
      int          port;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cycle = 0;

   always @(posedge r_ver_clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare every read data phase scheduled for this cycle
   always @(negedge r_ver_clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cycle) begin
         e = sb.pop_front();
         if (e.cyc < cycle) begin
            check({e.name, "_missed"}, 32'(e.cyc), 32'(cycle));
         end else begin
            check(e.name, ahb.s_hrdata_o[e.port], e.exp);
            check({e.name, "_rdy"}, {31'b0, ahb.s_hready_o[e.port]}, 32'h1);
            check({e.name, "_resp"}, {31'b0, ahb.s_hresp_o[e.port]}, 32'h0);
         end
      end
   end

   task automatic tick();
      @(posedge r_ver_clk);
      #1;
   endtask

   task automatic idle(input int p);
      ahb.s_hsel_i[p]   = 1'b0;
      ahb.s_htrans_i[p] = 2'b00;
      ahb.s_hwrite_i[p] = 1'b0;
      ahb.s_haddr_i[p]  = '0;
      ahb.s_hsize_i[p]  = 3'd0;
   endtask

   task automatic addr_ph(input int p, input logic [AW-1:0] a, input logic w,
                          input logic [2:0] sz, input logic [1:0] tr = 2'b10,
                          input logic sel = 1'b1);
      ahb.s_hsel_i[p]   = sel;
      ahb.s_htrans_i[p] = tr;
      ahb.s_hwrite_i[p] = w;
      ahb.s_haddr_i[p]  = a;
      ahb.s_hsize_i[p]  = sz;
   endtask

   task automatic expect_rd(input int p, input logic [31:0] d, input string n);
      exp_t e;
      e.cyc  = cycle + 1;
      e.port = p;
      e.exp  = d;
      e.name = n;
      sb.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      for (int p = 0; p < 2; p++) begin
         idle(p);
         ahb.s_hwdata_i[p]    = 32'h0;
         ahb.s_hburst_i[p]    = 3'd0;
         ahb.s_hmastlock_i[p] = 1'b0;
         ahb.s_hprot_i[p]     = 4'd0;
      end
      #1;
      dut.r_memory[0] = 32'h00112233;
      dut.r_memory[2] = 32'h12345678;
      dut.r_memory[3] = 32'h33333333;
      dut.r_memory[4] = 32'h00000000;
      dut.r_memory[5] = 32'hA5A5A5A5;
      dut.r_memory[6] = 32'h66666666;
      dut.r_memory[7] = 32'h77777777;
      dut.r_memory[8] = 32'h88888888;
      tick();
      tick();
      for (int p = 0; p < 2; p++) begin
         check($sformatf("rst_rdata%0d", p), ahb.s_hrdata_o[p], 32'h0);
         check($sformatf("rst_ready%0d", p), {31'b0, ahb.s_hready_o[p]}, 32'h1);
         check($sformatf("rst_resp%0d", p), {31'b0, ahb.s_hresp_o[p]}, 32'h0);
      end
      rst_n = 1'b1;
      tick();

      // preloaded word survives reset and reads back one cycle later
      addr_ph(0, 10'h000, 1'b0, 3'd2);
      expect_rd(0, 32'h00112233, "rd_preload");
      tick(); idle(0); tick();

      // byte write on port 1, read issued during its data phase sees new data
      addr_ph(1, 10'h003, 1'b1, 3'd0);
      tick(); idle(1);
      ahb.s_hwdata_i[1] = 32'hAB000000;
      addr_ph(0, 10'h000, 1'b0, 3'd2);
      expect_rd(0, 32'hAB112233, "rd_after_byte_wr");
      tick(); idle(0);
      check("mem0_byte_wr", dut.r_memory[0], 32'hAB112233);

      // half write, bypass read from the other port
      addr_ph(1, 10'h008, 1'b1, 3'd1);
      tick(); idle(1);
      ahb.s_hwdata_i[1] = 32'h0000BEEF;
      addr_ph(0, 10'h008, 1'b0, 3'd2);
      expect_rd(0, 32'h1234BEEF, "rd_half_bypass");
      tick(); idle(0);
      check("mem2_half_wr", dut.r_memory[2], 32'h1234BEEF);

      // read data phase coinciding with write data phase returns old word
      addr_ph(0, 10'h00C, 1'b0, 3'd2);
      addr_ph(1, 10'h00C, 1'b1, 3'd2);
      expect_rd(0, 32'h33333333, "rd_old_data");
      tick(); idle(0); idle(1);
      ahb.s_hwdata_i[1] = 32'h99999999;
      tick();
      check("mem3_word_wr", dut.r_memory[3], 32'h99999999);

      // same-word collision: port 1 wins
      addr_ph(0, 10'h010, 1'b1, 3'd2);
      addr_ph(1, 10'h010, 1'b1, 3'd2);
      tick(); idle(0); idle(1);
      ahb.s_hwdata_i[0] = 32'h11111111;
      ahb.s_hwdata_i[1] = 32'h22222222;
      tick();
      check("mem4_collision", dut.r_memory[4], 32'h22222222);

      // disjoint bytes of one word both land
      addr_ph(0, 10'h014, 1'b1, 3'd0);
      addr_ph(1, 10'h015, 1'b1, 3'd0);
      tick(); idle(0); idle(1);
      ahb.s_hwdata_i[0] = 32'h000000C3;
      ahb.s_hwdata_i[1] = 32'h0000D400;
      tick();
      check("mem5_disjoint", dut.r_memory[5], 32'hA5A5D4C3);

      // oversize write is dropped
      addr_ph(0, 10'h018, 1'b1, 3'd3);
      tick(); idle(0);
      ahb.s_hwdata_i[0] = 32'hFFFFFFFF;
      tick();
      check("mem6_size3", dut.r_memory[6], 32'h66666666);

      // IDLE on port 0, unselected port 1: no write, read data 0
      addr_ph(0, 10'h01C, 1'b1, 3'd2, 2'b00, 1'b1);
      addr_ph(1, 10'h01C, 1'b1, 3'd2, 2'b10, 1'b0);
      expect_rd(0, 32'h0, "idle_rdata0");
      expect_rd(1, 32'h0, "nosel_rdata1");
      tick(); idle(0); idle(1);
      ahb.s_hwdata_i[0] = 32'hDEADBEEF;
      ahb.s_hwdata_i[1] = 32'hDEADBEEF;
      tick();
      check("mem7_idle", dut.r_memory[7], 32'h77777777);

      // BUSY read is not accepted
      addr_ph(0, 10'h000, 1'b0, 3'd2, 2'b01, 1'b1);
      expect_rd(0, 32'h0, "busy_rdata0");
      tick(); idle(0); tick();

      // reset in the middle of a write data phase discards it
      addr_ph(0, 10'h020, 1'b1, 3'd2);
      tick(); idle(0);
      ahb.s_hwdata_i[0] = 32'hFFFFFFFF;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_rdata", ahb.s_hrdata_o[0], 32'h0);
      check("midrst_ready", {31'b0, ahb.s_hready_o[0]}, 32'h1);
      check("midrst_resp", {31'b0, ahb.s_hresp_o[0]}, 32'h0);
      tick();
      check("mem8_rst_wr", dut.r_memory[8], 32'h88888888);
      rst_n = 1'b1;
      tick(); tick(); tick();

      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dahb_ram_block.md
DAHB_RAM_BLOCK -- requirements
Module: dahb_ram

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- MEM_SIZE, 32'h100000, memory size in bytes, power of two, at least 8.
- SIMULATION, 0, 1 enables simulation-only features.
- ENABLE_LOG, 0, 1 with SIMULATION=1 enables the transfer log.
- LABEL, "MEMORY", string prefix used in log lines.

REQ-002 Ports SHALL be (name, direction, width, meaning); AW = log2(MEM_SIZE); every port except clock and reset is an unpacked array [2], with index 0 the instruction port and index 1 the data port:
- s_clk_i, in, 1, the single clock.
- s_resetn_i, in, 1, reset; asynchronous, active-low.
- s_haddr_i, in, AW, byte address.
- s_hwdata_i, in, 32, write data.
- s_hburst_i, in, 3, ignored.
- s_hmastlock_i, in, 1, ignored.
- s_hprot_i, in, 4, ignored.
- s_hsize_i, in, 3, transfer size.
- s_htrans_i, in, 2, transfer type.
- s_hwrite_i, in, 1, 1 = write.
- s_hsel_i, in, 1, port select.
- s_hrdata_o, out, 32, read data.
- s_hready_o, out, 1, always 1.
- s_hresp_o, out, 1, always 0 (OKAY).

REQ-003 Storage SHALL be one array r_memory of MEM_SIZE/4 32-bit words, indexed by address[AW-1:2], little-endian, hierarchically accessible for preload and inspection.

Function
REQ-004 Each port SHALL be an independent AHB3-Lite zero-wait-state slave sharing r_memory.
REQ-005 Per port, an address phase is accepted on a rising edge when s_hsel_i=1 and s_htrans_i[1]=1 (NONSEQ or SEQ).
REQ-006 On acceptance, the port SHALL register valid, write, size and address for the following data phase.
REQ-007 When no transfer is accepted, or when htrans is IDLE or BUSY, the registered valid SHALL be cleared.
REQ-008 Write data phase: on the rising edge ending the data phase, the port SHALL update the bytes selected by the registered size and address[1:0] with the matching lanes of s_hwdata_i:
- Byte: lane addr[1:0].
- Half: lanes {addr[1],0} and {addr[1],1}.
- Word: all four lanes.
REQ-009 A write with registered size greater than 2 SHALL leave r_memory unchanged.
REQ-010 Read data phase: s_hrdata_o SHALL combinationally equal r_memory[registered address[AW-1:2]], always the full word; the master selects lanes.
REQ-011 s_hrdata_o SHALL be 0 when the port has no valid read data phase.
REQ-012 Write visibility:
- A read whose address phase coincides with a write data phase to the same word SHALL return the new data, on either port.
- A read data phase coinciding with a write data phase to the same word SHALL return the old data.
REQ-013 Simultaneous writes from both ports to the same byte SHALL resolve in favour of port 1; disjoint bytes of the same word SHALL both be written.
REQ-014 Addresses SHALL wrap modulo MEM_SIZE; there are no error responses; s_hready_o=1 and s_hresp_o=0 in every cycle.
REQ-015 With SIMULATION=1 and ENABLE_LOG=1, each completed data phase SHALL print LABEL, port index, R/W, address and data; otherwise nothing is printed.
REQ-016 Memory latency SHALL be 1 cycle from address phase to data, with no stalls; the block SHALL contain no other state machine.

Reset
REQ-017 While s_resetn_i=0, both ports' registered valid, write, size and address SHALL be 0, so s_hrdata_o=0.
REQ-018 Reset SHALL NOT modify r_memory; contents preloaded before reset release SHALL be preserved.
REQ-019 Asserting reset during a write data phase SHALL discard that write.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Preload r_memory[0]=32'h00112233 and release reset; port 0 word read at addr 0 -> s_hrdata_o[0]=32'h00112233 one cycle later, s_hready_o=1.
- Port 1 byte write of 32'hAB000000 at addr 0x3 with size 0 -> r_memory[0]=32'hAB112233.
- Port 1 half write of 32'h0000BEEF at addr 0x8 with size 1, then word read on port 0 at 0x8 issued in the write data-phase cycle -> 32'h????BEEF, with untouched upper lanes retained.
- Both ports write addr 0x10 in the same cycle (port 0 32'h11111111, port 1 32'h22222222) -> r_memory[4]=32'h22222222.
- htrans=IDLE or s_hsel_i=0 with s_hwrite_i=1 -> no memory change, s_hrdata_o=0 in the next cycle.
- Reset asserted mid write data phase -> memory unchanged, outputs 0/1/0 for hrdata/hready/hresp.
